// File: rtl/lru_ctrl_if.sv
// Handshake bundle for lru_ctrl: update port, victim query port and invalidate control.
interface lru_ctrl_if #(
    parameter int IDX_W = 6
);
    logic             upd_valid;
    logic             upd_ready;
    logic [IDX_W-1:0] upd_idx;
    logic [3:0]       upd_way;
    logic             vic_valid;
    logic             vic_ready;
    logic [IDX_W-1:0] vic_idx;
    logic             vic_rvalid;
    logic [3:0]       vic_way;
    logic             inv_start;
    logic             inv_busy;

    modport master (
        output upd_valid, upd_idx, upd_way, vic_valid, vic_idx, inv_start,
        input  upd_ready, vic_ready, vic_rvalid, vic_way, inv_busy
    );

    modport slave (
        input  upd_valid, upd_idx, upd_way, vic_valid, vic_idx, inv_start,
        output upd_ready, vic_ready, vic_rvalid, vic_way, inv_busy
    );
endinterface

// File: rtl/lru_ctrl.sv
// 4-way pseudo-pairwise LRU state tracker with victim query and full-array clear sweep.
// Optional macro LRU_CTRL_BYPASS_EN forwards a same-cycle update into a query on the same set.
module lru_ctrl #(
    parameter int SETS     = 64,
    parameter int IDX_W    = 6,
    parameter int LRU_BITS = 6
) (
    input  logic       clk,
    input  logic       resetn,
    lru_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {INIT, RUN, INV} state_e;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(SETS - 1);

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 rdy_q, rdy_d;
    logic                 vic_rvalid_q, vic_rvalid_d;
    logic [3:0]           vic_way_q, vic_way_d;
    logic [LRU_BITS-1:0]  mem_q [SETS];

    logic                 upd_fire, upd_onehot, upd_we, vic_fire, sweep_we;
    logic [3:0]           w;
    logic [LRU_BITS-1:0]  upd_old, upd_mask, upd_data, upd_wdata, vic_rd;

    // Bit pairs: L5=0v1 L4=0v2 L3=0v3 L2=1v2 L1=1v3 L0=2v3, set means the lower way is newer.
    function automatic logic [3:0] lru_decode(input logic [LRU_BITS-1:0] l);
        logic w0, w1, w2;
        w0 = ~l[5] & ~l[4] & ~l[3];
        w1 =  l[5] & ~l[2] & ~l[1];
        w2 =  l[4] &  l[2] & ~l[0];
        return {~(w0 | w1 | w2), w2, w1, w0};
    endfunction

    assign w          = bus.upd_way;
    assign upd_fire   = bus.upd_valid & rdy_q;
    assign vic_fire   = bus.vic_valid & rdy_q;
    assign upd_onehot = (w != 4'b0000) && ((w & (w - 4'b0001)) == 4'b0000);
    assign upd_we     = upd_fire & upd_onehot;
    assign sweep_we   = (state_q != RUN);

    assign upd_old   = mem_q[bus.upd_idx];
    assign upd_data  = LRU_BITS'({w[0], w[0], w[0], w[1], w[1], w[2]});
    assign upd_mask  = ({LRU_BITS{w[0]}} & LRU_BITS'(6'b111000))
                     | ({LRU_BITS{w[1]}} & LRU_BITS'(6'b100110))
                     | ({LRU_BITS{w[2]}} & LRU_BITS'(6'b010101))
                     | ({LRU_BITS{w[3]}} & LRU_BITS'(6'b001011));
    assign upd_wdata = (upd_old & ~upd_mask) | (upd_data & upd_mask);

`ifdef LRU_CTRL_BYPASS_EN
    assign vic_rd = (upd_we && (bus.upd_idx == bus.vic_idx)) ? upd_wdata : mem_q[bus.vic_idx];
`else
    assign vic_rd = mem_q[bus.vic_idx];
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        busy_d       = busy_q;
        rdy_d        = rdy_q;
        vic_rvalid_d = vic_fire;
        vic_way_d    = vic_fire ? lru_decode(vic_rd) : vic_way_q;
        case (state_q)
            INIT, INV: begin
                cnt_d = cnt_q + IDX_W'(1);
                if (cnt_q == LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    rdy_d   = 1'b1;
                end
            end
            RUN: begin
                if (bus.inv_start) begin
                    state_d = INV;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    rdy_d   = 1'b0;
                end
            end
            default: begin
                state_d = INIT;
                cnt_d   = '0;
                busy_d  = 1'b1;
                rdy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= INIT;
            cnt_q        <= '0;
            busy_q       <= 1'b1;
            rdy_q        <= 1'b0;
            vic_rvalid_q <= 1'b0;
            vic_way_q    <= 4'b0000;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            rdy_q        <= rdy_d;
            vic_rvalid_q <= vic_rvalid_d;
            vic_way_q    <= vic_way_d;
        end
    end

    // No reset on the array: the INIT sweep clears it; sweep and update never overlap.
    always_ff @(posedge clk) begin
        if (sweep_we)
            mem_q[cnt_q] <= '0;
        else if (upd_we)
            mem_q[bus.upd_idx] <= upd_wdata;
    end

    assign bus.upd_ready  = rdy_q;
    assign bus.vic_ready  = rdy_q;
    assign bus.inv_busy   = busy_q;
    assign bus.vic_rvalid = vic_rvalid_q;
    assign bus.vic_way    = vic_way_q;

endmodule

// File: tb/tb_lru_ctrl.sv
// Directed self-checking bench for lru_ctrl: init/inv sweep timing, update/decode, bypass, reset.
module tb_lru_ctrl;
    localparam int SETS  = 64;
    localparam int IDX_W = 6;
`ifdef LRU_CTRL_BYPASS_EN
    localparam logic [3:0] BYP_EXP = 4'b0010;
`else
    localparam logic [3:0] BYP_EXP = 4'b0001;
`endif

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   n;

    always #5 clk = ~clk;

    lru_ctrl_if #(.IDX_W(IDX_W)) bus();

    lru_ctrl #(.SETS(SETS), .IDX_W(IDX_W), .LRU_BITS(6)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic idle();
        bus.upd_valid = 1'b0;
        bus.upd_idx   = '0;
        bus.upd_way   = 4'b0000;
        bus.vic_valid = 1'b0;
        bus.vic_idx   = '0;
        bus.inv_start = 1'b0;
    endtask

    // Drive one cycle of inputs, step past the edge, sample 1ns later.
    task automatic cyc(input logic uv, input logic [5:0] ui, input logic [3:0] uw,
                       input logic qv, input logic [5:0] qi, input logic inv);
        bus.upd_valid = uv;
        bus.upd_idx   = ui;
        bus.upd_way   = uw;
        bus.vic_valid = qv;
        bus.vic_idx   = qi;
        bus.inv_start = inv;
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic query(input string tag, input logic [5:0] idx, input logic [3:0] exp);
        cyc(1'b0, '0, 4'b0000, 1'b1, idx, 1'b0);
        chk({tag, "_rv"}, 32'(bus.vic_rvalid), 32'd1);
        chk(tag, 32'(bus.vic_way), 32'(exp));
    endtask

    // Counts sampled cycles with inv_busy high; optional stray inv_start at sample pulse_at.
    task automatic count_busy(input int pulse_at, output int cnt);
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            if (!bus.inv_busy) break;
            if (i == pulse_at) bus.inv_start = 1'b1;
            cnt++;
            @(posedge clk);
            #1;
            bus.inv_start = 1'b0;
        end
    endtask

    initial begin
        logic [3:0] wy;
        logic [5:0] post_idx [4];
        post_idx = '{6'd0, 6'd4, 6'd5, 6'd63};
        idle();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",   32'(bus.inv_busy),   32'd1);
        chk("rst_urdy",   32'(bus.upd_ready),  32'd0);
        chk("rst_vrdy",   32'(bus.vic_ready),  32'd0);
        chk("rst_rvalid", 32'(bus.vic_rvalid), 32'd0);
        chk("rst_way",    32'(bus.vic_way),    32'd0);
        resetn = 1'b1;
        count_busy(-1, n);
        chk("init_len", 32'(n), 32'd64);
        chk("init_urdy", 32'(bus.upd_ready), 32'd1);
        chk("init_vrdy", 32'(bus.vic_ready), 32'd1);

        query("q_fresh", 6'd5, 4'b0001);
        @(posedge clk);
        #1;
        chk("rv_pulse", 32'(bus.vic_rvalid), 32'd0);

        // set 5: 111000 -> way1 LRU; then way1 update gives 011110 -> way2 LRU
        cyc(1'b1, 6'd5, 4'b0001, 1'b0, '0, 1'b0);
        query("q_w0", 6'd5, 4'b0010);
        cyc(1'b1, 6'd5, 4'b0010, 1'b0, '0, 1'b0);
        query("q_w1", 6'd5, 4'b0100);
        cyc(1'b1, 6'd5, 4'b0011, 1'b0, '0, 1'b0);
        query("q_multi", 6'd5, 4'b0100);
        cyc(1'b1, 6'd5, 4'b0000, 1'b0, '0, 1'b0);
        query("q_zero", 6'd5, 4'b0100);

        cyc(1'b1, 6'd6, 4'b0001, 1'b1, 6'd6, 1'b0);
        chk("byp_rv", 32'(bus.vic_rvalid), 32'd1);
        chk("byp", 32'(bus.vic_way), 32'(BYP_EXP));
        query("q_after_byp", 6'd6, 4'b0010);

        // set 7 back-to-back: 111000 -> 011110 -> 001011 -> way3 LRU
        cyc(1'b1, 6'd7, 4'b0001, 1'b0, '0, 1'b0);
        cyc(1'b1, 6'd7, 4'b0010, 1'b0, '0, 1'b0);
        cyc(1'b1, 6'd7, 4'b0100, 1'b0, '0, 1'b0);
        query("q_b2b", 6'd7, 4'b1000);

        bus.vic_valid = 1'b1;
        bus.vic_idx   = 6'd5;
        @(posedge clk);
        #1;
        chk("pipe0", 32'(bus.vic_way), 32'b0100);
        bus.vic_idx = 6'd7;
        @(posedge clk);
        #1;
        chk("pipe1_rv", 32'(bus.vic_rvalid), 32'd1);
        chk("pipe1", 32'(bus.vic_way), 32'b1000);
        idle();

        for (int i = 0; i < SETS; i++) begin
            wy = 4'b0001 << (i % 4);
            cyc(1'b1, 6'(i), wy, 1'b0, '0, 1'b0);
        end
        query("pre_inv0", 6'd0, 4'b0010);
        query("pre_inv4", 6'd4, 4'b0010);

        cyc(1'b0, '0, 4'b0000, 1'b1, 6'd0, 1'b1);
        chk("inv_q_rv", 32'(bus.vic_rvalid), 32'd1);
        chk("inv_q_kept", 32'(bus.vic_way), 32'b0010);
        chk("inv_urdy", 32'(bus.upd_ready), 32'd0);
        count_busy(10, n);
        chk("inv_len", 32'(n), 32'd64);
        foreach (post_idx[k])
            query($sformatf("post_inv%0d", post_idx[k]), post_idx[k], 4'b0001);

        cyc(1'b0, '0, 4'b0000, 1'b0, '0, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        resetn = 1'b0;
        #2;
        chk("mid_rst_busy", 32'(bus.inv_busy),   32'd1);
        chk("mid_rst_rdy",  32'(bus.vic_ready),  32'd0);
        chk("mid_rst_way",  32'(bus.vic_way),    32'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        count_busy(-1, n);
        chk("mid_rst_len", 32'(n), 32'd64);
        query("post_rst", 6'd7, 4'b0001);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
